// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
//   Shared types and constants for the pushbutton front-end blocks.
//   Holds the debouncer FSM state encoding and the default debounce length
//   for the 50 MHz board clock.
// ---------------------------------------------------------------------------
package button_pkg;

    // Debouncer FSM states. The two *_WAIT states count stable samples
    // before committing to a press or a release.
    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    // 20 ms of stable input at a 50 MHz clock.
    localparam int DEBOUNCE_20MS_50MHZ = 1_000_000;

endpackage : button_pkg

// File: rtl/button_enable_pulser_sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
//   Flop-based synchroniser for a single asynchronous board input.
//   Reusable for any pin that needs to enter the clk domain.
//
// Parameters
//   STAGES     number of flops in the chain (at least 2)
//   RESET_VAL  value loaded into every flop during reset
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-low reset (0 = reset asserted)
//   d      in   asynchronous input
//   q      out  synchronised copy of d, STAGES edges late
// ---------------------------------------------------------------------------
module sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    // A single flop gives no metastability protection, so refuse to build.
    if (STAGES < 2) begin : g_stages_check
        $error("sync_chain: STAGES must be at least 2");
    end

    logic [STAGES-1:0] sync_q;

    // Shift register: the input enters at bit 0 and leaves at the top bit.
    // Reset loads the idle level so downstream logic sees no spurious edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : sync_chain

// File: rtl/button_enable_pulser.sv
// ---------------------------------------------------------------------------
// button_enable_pulser
//   Turns a raw, bouncing pushbutton into a clean single-cycle enable pulse
//   for load-enabled registers, plus a debounced pressed level.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a press or
//                    a release (at least 2)
//   SYNC_STAGES      synchroniser depth (at least 2)
//   BTN_ACTIVE_LOW   1: btn_raw=0 means pressed; 0: btn_raw=1 means pressed
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-low reset (0 = reset asserted)
//   btn_raw    in   asynchronous pushbutton pin
//   enable     out  one-cycle pulse per accepted press (registered)
//   btn_level  out  debounced pressed level, 1 = pressed (registered)
// ---------------------------------------------------------------------------
module button_enable_pulser
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
    parameter int SYNC_STAGES     = 2,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic enable,
    output logic btn_level
);

    if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2) begin : g_param_check
        $error("button_enable_pulser: DEBOUNCE_CYCLES and SYNC_STAGES must both be at least 2");
    end

    // The counter only ever needs to reach DEBOUNCE_CYCLES-1.
    localparam int               CNT_W        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic             RELEASED_RAW = BTN_ACTIVE_LOW;

    logic             btn_sync;
    logic             pressed_s;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             enable_next;
    logic             btn_level_next;

    // The synchroniser resets to the released pin level so that leaving
    // reset with the button up never looks like a press.
    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RELEASED_RAW)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (btn_sync)
    );

    // Normalise polarity so the rest of the logic always treats 1 as pressed.
    assign pressed_s = btn_sync ^ BTN_ACTIVE_LOW;

    // State, counter and both outputs are registered together; reset
    // discards any press in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            enable    <= 1'b0;
            btn_level <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            enable    <= enable_next;
            btn_level <= btn_level_next;
        end
    end

    // Debounce FSM. Any sample that disagrees with the pending transition
    // sends the FSM back to its previous stable state. enable defaults low,
    // so it is high only for the one cycle after entering HELD from a
    // qualified press; returning to HELD from a release bounce never
    // re-pulses.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        enable_next    = 1'b0;
        btn_level_next = btn_level;

        unique case (state)
            IDLE: begin
                if (pressed_s) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = CNT_ONE;
                end
            end

            PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next     = HELD;
                    enable_next    = 1'b1;
                    btn_level_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end

            HELD: begin
                if (!pressed_s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = CNT_ONE;
                end
            end

            RELEASE_WAIT: begin
                if (pressed_s) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next     = IDLE;
                    btn_level_next = 1'b0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end

            default: begin
                state_next     = IDLE;
                cnt_next       = '0;
                btn_level_next = 1'b0;
            end
        endcase
    end

endmodule : button_enable_pulser

// File: tb/tb_button_enable_pulser.sv
// ---------------------------------------------------------------------------
// tb_button_enable_pulser
//   Directed bench for button_enable_pulser with DEBOUNCE_CYCLES=4,
//   SYNC_STAGES=2 and an active-low button. With these settings a pin change
//   first sampled at edge 0 shows up on the outputs after edge 5.
//   A 2-bit load-enabled register driven by enable stands in for a real
//   consumer of the pulse.
// ---------------------------------------------------------------------------
module tb_button_enable_pulser;

    logic       clk;
    logic       reset;
    logic       btn_raw;
    logic       enable;
    logic       btn_level;
    logic [1:0] data_in;
    logic [1:0] data_out;

    int tests_run = 0;
    int tests_failed = 0;

    button_enable_pulser #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .enable    (enable),
        .btn_level (btn_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Load-enabled consumer register; its own reset is never asserted.
    initial data_out = 2'b00;
    always @(posedge clk) begin
        if (enable) data_out <= data_in;
    end

    // Drive the inputs, take one rising edge, then settle before sampling.
    task automatic applyStimulus(input logic raw, input logic rst_n);
        btn_raw = raw;
        reset   = rst_n;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] observed,
                               input logic [1:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    // Pressed bounce pattern (active low) for the press-bounce step.
    logic press_bounce [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    // Release bounce pattern for the release-bounce step.
    logic release_bounce [3] = '{1'b1, 1'b1, 1'b0};

    initial begin
        btn_raw = 1'b1;
        reset   = 1'b0;
        data_in = 2'b00;

        // 1. Reset held for three cycles with the button up.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("reset_enable_%0d", k), {1'b0, enable}, 2'b00);
            checkOutput($sformatf("reset_level_%0d", k), {1'b0, btn_level}, 2'b00);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("post_reset_%0d", k), {enable, btn_level}, 2'b00);
        end

        // 2. Clean press held for 20 cycles: one pulse after edge 5.
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("press_enable_%0d", k), {1'b0, enable}, {1'b0, k == 5});
            checkOutput($sformatf("press_level_%0d", k), {1'b0, btn_level}, {1'b0, k >= 5});
        end
        // Clean release: level falls after edge 5, no pulse.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("release_%0d", k), {enable, btn_level}, {1'b0, k < 5});
        end

        // 3. Press bounce, then stable press.
        for (int k = 0; k < 7; k++) begin
            applyStimulus(press_bounce[k], 1'b1);
            checkOutput($sformatf("pbounce_%0d", k), {enable, btn_level}, 2'b00);
        end
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("pstable_%0d", k), {enable, btn_level}, {k == 5, k >= 5});
        end

        // 4. Release bounce from HELD, then stable release.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(release_bounce[k], 1'b1);
            checkOutput($sformatf("rbounce_%0d", k), {enable, btn_level}, 2'b01);
        end
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("rstable_%0d", k), {enable, btn_level}, {1'b0, k < 5});
        end

        // 5. Reset while HELD with the button still down.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("hold_pre_%0d", k), {enable, btn_level}, {k == 5, k >= 5});
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("midhold_reset", {enable, btn_level}, 2'b00);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("after_reset_%0d", k), {enable, btn_level}, {k == 5, k >= 5});
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("release5_%0d", k), {enable, btn_level}, {1'b0, k < 5});
        end

        // 6. Pulse loads the consumer register exactly once per press.
        checkOutput("reg_before", data_out, 2'b00);
        data_in = 2'b10;
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput("reg_loaded", data_out, 2'b10);
        data_in = 2'b01;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput("reg_held", data_out, 2'b10);
        checkOutput("reg_held_flags", {enable, btn_level}, 2'b01);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b1);
        end
        checkOutput("reg_released", data_out, 2'b10);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput("reg_second_press", data_out, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_button_enable_pulser
